// File: rtl/cat_mode_sequencer.sv
// Mode sequencer for the CAT CMOS IO block: switches between SISO and MIMO,
// resets the IO block, waits for it to settle, checks the RX strobe pattern for
// lock and monitors lock while running. TX is gated off unless the link is locked.
// Handshake: mode_req_stb is a single-cycle qualifier with no back-pressure;
// mode_req is sampled only on a cycle where mode_req_stb is high.
module cat_mode_sequencer #(
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_COUNT    = 8,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       radio_clk,
  input  logic       radio_rst,
  input  logic       mode_req,
  input  logic       mode_req_stb,
  input  logic       rx_stb,
  output logic       mimo,
  output logic       io_areset,
  output logic       tx_enable,
  output logic       locked,
  output logic       busy,
  output logic       lock_err,
  output logic [7:0] relock_cnt,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_SETTLE  = 3'd1,
    S_LOCK    = 3'd2,
    S_RUN     = 3'd3,
    S_QUIESCE = 3'd4,
    S_FAIL    = 3'd5
  } state_t;

  // One shared phase counter serves RESET, SETTLE and QUIESCE.
  localparam int CNT_MAX  = (SETTLE_CYCLES > 4) ? SETTLE_CYCLES : 4;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int MATCH_W  = $clog2(LOCK_COUNT + 1);
  localparam int TO_W     = $clog2(LOCK_TIMEOUT + 1);
  localparam int RETRY_W  = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   QUIESCE_LAST = CNT_W'(3);
  localparam logic [MATCH_W-1:0] MATCH_DONE   = MATCH_W'(LOCK_COUNT);
  localparam logic [TO_W-1:0]    TO_DONE      = TO_W'(LOCK_TIMEOUT);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [TO_W-1:0]      timeout_q, timeout_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 pending_q, pending_d;
  logic                 lock_err_q, lock_err_d;
  logic [7:0]           relock_q, relock_d;
  logic                 bad_q, bad_d;
  logic                 prev_rx_q;
  logic                 mimo_q;
  logic                 io_areset_q, tx_enable_q, locked_q, busy_q;
  logic                 good;
  logic                 accept;
  logic                 lost;

  // MIMO strobes alternate every cycle; SISO strobes are continuously high.
  assign good = mimo_q ? (rx_stb != prev_rx_q) : rx_stb;

  // Next-state, counter and request-capture logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    match_d    = match_q;
    timeout_d  = timeout_q;
    retry_d    = retry_q;
    pending_d  = pending_q;
    lock_err_d = lock_err_q;
    relock_d   = relock_q;
    bad_d      = bad_q;
    accept     = 1'b0;
    lost       = 1'b0;

    // In RUN only a request for the other mode is taken; elsewhere the latest wins.
    if (mode_req_stb) begin
      if (state_q == S_RUN) begin
        if (mode_req != mimo_q) begin
          pending_d = mode_req;
          accept    = 1'b1;
        end
      end else begin
        pending_d = mode_req;
        accept    = 1'b1;
      end
    end
    if (accept) lock_err_d = 1'b0;

    case (state_q)
      S_RESET: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d   = S_LOCK;
          cnt_d     = '0;
          match_d   = '0;
          timeout_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOCK: begin
        timeout_d = timeout_q + 1'b1;
        match_d   = good ? (match_q + 1'b1) : '0;
        if (match_d == MATCH_DONE) begin
          retry_d = '0;
          bad_d   = 1'b0;
          cnt_d   = '0;
          // A mode change still outstanding means this lock is for the wrong mode.
          state_d = (pending_d != mimo_q) ? S_QUIESCE : S_RUN;
        end else if (timeout_d == TO_DONE) begin
          lock_err_d = 1'b1;
          retry_d    = retry_q + 1'b1;
          cnt_d      = '0;
          state_d    = (retry_d < RETRY_LIMIT) ? S_RESET : S_FAIL;
        end
      end
      S_RUN: begin
        // A single bad strobe cycle is tolerated; two in a row drop lock.
        lost  = !good && bad_q;
        bad_d = !good;
        if (lost && (relock_q != 8'hFF)) relock_d = relock_q + 8'd1;
        if (lost || accept) begin
          state_d = S_QUIESCE;
          cnt_d   = '0;
        end
      end
      S_QUIESCE: begin
        if (cnt_q == QUIESCE_LAST) begin
          state_d = S_RESET;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FAIL: begin
        if (mode_req_stb) begin
          retry_d = '0;
          state_d = S_QUIESCE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge radio_clk) begin
    if (radio_rst) begin
      state_q     <= S_RESET;
      cnt_q       <= '0;
      match_q     <= '0;
      timeout_q   <= '0;
      retry_q     <= '0;
      pending_q   <= 1'b0;
      lock_err_q  <= 1'b0;
      relock_q    <= 8'd0;
      bad_q       <= 1'b0;
      prev_rx_q   <= 1'b0;
      mimo_q      <= 1'b0;
      io_areset_q <= 1'b1;
      tx_enable_q <= 1'b0;
      locked_q    <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      match_q     <= match_d;
      timeout_q   <= timeout_d;
      retry_q     <= retry_d;
      pending_q   <= pending_d;
      lock_err_q  <= lock_err_d;
      relock_q    <= relock_d;
      bad_q       <= bad_d;
      prev_rx_q   <= rx_stb;
      // The IO block mode only changes while it is being held in reset.
      if ((state_d == S_RESET) && (state_q != S_RESET)) mimo_q <= pending_d;
      io_areset_q <= (state_d == S_RESET);
      tx_enable_q <= (state_d == S_RUN);
      locked_q    <= (state_d == S_RUN);
      busy_q      <= (state_d != S_RUN) && (state_d != S_FAIL);
    end
  end

  assign mimo       = mimo_q;
  assign io_areset  = io_areset_q;
  assign tx_enable  = tx_enable_q;
  assign locked     = locked_q;
  assign busy       = busy_q;
  assign lock_err   = lock_err_q;
  assign relock_cnt = relock_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_cat_mode_sequencer.sv
// Directed bench for cat_mode_sequencer with default parameters.
module tb_cat_mode_sequencer;

  // Expected-phase codes, local to the bench.
  localparam logic [2:0] X_RST = 3'd0, X_SET = 3'd1, X_LCK = 3'd2,
                         X_RUN = 3'd3, X_QSC = 3'd4, X_FAIL = 3'd5;
  // rx_stb drive modes.
  localparam logic [1:0] R_ZERO = 2'd0, R_ONE = 2'd1, R_TGL = 2'd2, R_HOLD = 2'd3;

  typedef struct {
    int         ticks;
    logic [1:0] rx;
    logic       stb;
    logic       mreq;
    logic [2:0] st;
    logic       mimo;
    logic       err;
    logic [7:0] rel;
  } step_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_req;
  logic       mode_req_stb;
  logic       rx_stb;
  logic       mimo;
  logic       io_areset;
  logic       tx_enable;
  logic       locked;
  logic       busy;
  logic       lock_err;
  logic [7:0] relock_cnt;
  logic [2:0] state_dbg;

  int errors = 0;
  int checks = 0;
  step_t steps[$];

  cat_mode_sequencer dut (
    .radio_clk    (clk),
    .radio_rst    (rst),
    .mode_req     (mode_req),
    .mode_req_stb (mode_req_stb),
    .rx_stb       (rx_stb),
    .mimo         (mimo),
    .io_areset    (io_areset),
    .tx_enable    (tx_enable),
    .locked       (locked),
    .busy         (busy),
    .lock_err     (lock_err),
    .relock_cnt   (relock_cnt),
    .state_dbg    (state_dbg)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic m,
                           input logic e, input logic [7:0] r);
    chk({tag, "_io_areset"}, {7'd0, io_areset}, {7'd0, st == X_RST});
    chk({tag, "_tx_enable"}, {7'd0, tx_enable}, {7'd0, st == X_RUN});
    chk({tag, "_locked"},    {7'd0, locked},    {7'd0, st == X_RUN});
    chk({tag, "_busy"},      {7'd0, busy},      {7'd0, (st != X_RUN) && (st != X_FAIL)});
    chk({tag, "_mimo"},      {7'd0, mimo},      {7'd0, m});
    chk({tag, "_lock_err"},  {7'd0, lock_err},  {7'd0, e});
    chk({tag, "_relock"},    relock_cnt,        r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_step(input string tag, input step_t s);
    for (int i = 0; i < s.ticks; i++) begin
      case (s.rx)
        R_ZERO:  rx_stb = 1'b0;
        R_ONE:   rx_stb = 1'b1;
        R_TGL:   rx_stb = ~rx_stb;
        default: rx_stb = rx_stb;
      endcase
      mode_req_stb = (i == 0) ? s.stb : 1'b0;
      mode_req     = s.mreq;
      tick();
    end
    mode_req_stb = 1'b0;
    check_all(tag, s.st, s.mimo, s.err, s.rel);
  endtask

  task automatic add(input int t, input logic [1:0] rx, input logic stb, input logic mreq,
                     input logic [2:0] st, input logic m, input logic e, input logic [7:0] r);
    step_t s;
    s.ticks = t; s.rx = rx; s.stb = stb; s.mreq = mreq;
    s.st = st; s.mimo = m; s.err = e; s.rel = r;
    steps.push_back(s);
  endtask

  initial begin
    step_t s;
    // Reset and power-up into SISO.
    add(15, R_ONE, 0, 0, X_RST, 0, 0, 0);
    add(1,  R_ONE, 0, 0, X_SET, 0, 0, 0);
    add(15, R_ONE, 0, 0, X_SET, 0, 0, 0);
    add(1,  R_ONE, 0, 0, X_LCK, 0, 0, 0);
    add(7,  R_ONE, 0, 0, X_LCK, 0, 0, 0);
    add(1,  R_ONE, 0, 0, X_RUN, 0, 0, 0);
    // Single bad cycle tolerated, two in a row drop lock.
    add(1,  R_ZERO, 0, 0, X_RUN, 0, 0, 0);
    add(1,  R_ONE,  0, 0, X_RUN, 0, 0, 0);
    add(1,  R_ZERO, 0, 0, X_RUN, 0, 0, 0);
    add(1,  R_ZERO, 0, 0, X_QSC, 0, 0, 1);
    add(3,  R_ONE,  0, 0, X_QSC, 0, 0, 1);
    add(1,  R_ONE,  0, 0, X_RST, 0, 0, 1);
    add(15, R_ONE,  0, 0, X_RST, 0, 0, 1);
    add(1,  R_ONE,  0, 0, X_SET, 0, 0, 1);
    add(15, R_ONE,  0, 0, X_SET, 0, 0, 1);
    add(1,  R_ONE,  0, 0, X_LCK, 0, 0, 1);
    add(7,  R_ONE,  0, 0, X_LCK, 0, 0, 1);
    add(1,  R_ONE,  0, 0, X_RUN, 0, 0, 1);
    // Switch to MIMO from RUN.
    add(1,  R_TGL, 1, 1, X_QSC, 0, 0, 1);
    add(3,  R_TGL, 0, 1, X_QSC, 0, 0, 1);
    add(1,  R_TGL, 0, 1, X_RST, 1, 0, 1);
    add(15, R_TGL, 0, 1, X_RST, 1, 0, 1);
    add(1,  R_TGL, 0, 1, X_SET, 1, 0, 1);
    add(15, R_TGL, 0, 1, X_SET, 1, 0, 1);
    add(1,  R_TGL, 0, 1, X_LCK, 1, 0, 1);
    add(7,  R_TGL, 0, 1, X_LCK, 1, 0, 1);
    add(1,  R_TGL, 0, 1, X_RUN, 1, 0, 1);
    // Same-mode request in RUN is ignored.
    add(1,  R_TGL, 1, 1, X_RUN, 1, 0, 1);
    add(3,  R_TGL, 0, 1, X_RUN, 1, 0, 1);
    // MIMO strobe stops toggling: lock lost, then three lock timeouts into FAIL.
    add(1,    R_HOLD, 0, 1, X_RUN,  1, 0, 1);
    add(1,    R_HOLD, 0, 1, X_QSC,  1, 0, 2);
    add(3,    R_ZERO, 0, 1, X_QSC,  1, 0, 2);
    add(1,    R_ZERO, 0, 1, X_RST,  1, 0, 2);
    add(15,   R_ZERO, 0, 1, X_RST,  1, 0, 2);
    add(1,    R_ZERO, 0, 1, X_SET,  1, 0, 2);
    add(15,   R_ZERO, 0, 1, X_SET,  1, 0, 2);
    add(1,    R_ZERO, 0, 1, X_LCK,  1, 0, 2);
    add(1023, R_ZERO, 0, 1, X_LCK,  1, 0, 2);
    add(1,    R_ZERO, 0, 1, X_RST,  1, 1, 2);
    add(16,   R_ZERO, 0, 1, X_SET,  1, 1, 2);
    add(16,   R_ZERO, 0, 1, X_LCK,  1, 1, 2);
    add(1023, R_ZERO, 0, 1, X_LCK,  1, 1, 2);
    add(1,    R_ZERO, 0, 1, X_RST,  1, 1, 2);
    add(32,   R_ZERO, 0, 1, X_LCK,  1, 1, 2);
    add(1023, R_ZERO, 0, 1, X_LCK,  1, 1, 2);
    add(1,    R_ZERO, 0, 1, X_FAIL, 1, 1, 2);
    add(5,    R_ZERO, 0, 1, X_FAIL, 1, 1, 2);
    // Leave FAIL with a SISO request.
    add(1,  R_ONE, 1, 0, X_QSC, 1, 0, 2);
    add(3,  R_ONE, 0, 0, X_QSC, 1, 0, 2);
    add(1,  R_ONE, 0, 0, X_RST, 0, 0, 2);
    add(16, R_ONE, 0, 0, X_SET, 0, 0, 2);
    // Requests during SETTLE only update pending; latest (SISO) wins.
    add(1,  R_ONE, 1, 1, X_SET, 0, 0, 2);
    add(1,  R_ONE, 1, 0, X_SET, 0, 0, 2);
    add(14, R_ONE, 0, 0, X_LCK, 0, 0, 2);
    add(7,  R_ONE, 0, 0, X_LCK, 0, 0, 2);
    add(1,  R_ONE, 0, 0, X_RUN, 0, 0, 2);
    // Pending mode differs at lock: straight to QUIESCE, never locked.
    add(2,  R_ZERO, 0, 0, X_QSC, 0, 0, 3);
    add(4,  R_ONE,  0, 0, X_RST, 0, 0, 3);
    add(32, R_ONE,  0, 0, X_LCK, 0, 0, 3);
    add(1,  R_ONE,  1, 1, X_LCK, 0, 0, 3);
    add(6,  R_ONE,  0, 1, X_LCK, 0, 0, 3);
    add(1,  R_ONE,  0, 1, X_QSC, 0, 0, 3);
    add(4,  R_ONE,  0, 1, X_RST, 1, 0, 3);
    add(32, R_ONE,  0, 1, X_LCK, 1, 0, 3);

    rst = 1'b1; rx_stb = 1'b1; mode_req = 1'b0; mode_req_stb = 1'b0;
    tick();
    tick();
    check_all("reset", X_RST, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < steps.size(); i++) begin
      run_step($sformatf("step%0d", i), steps[i]);
    end

    // Reset in the middle of LOCK with a MIMO request pending.
    s.ticks = 2; s.rx = R_ONE; s.stb = 1; s.mreq = 1;
    s.st = X_LCK; s.mimo = 1; s.err = 0; s.rel = 3;
    run_step("lock_pre_rst", s);
    rst = 1'b1;
    tick();
    check_all("mid_rst", X_RST, 0, 0, 0);
    rst = 1'b0;
    s.ticks = 39; s.stb = 0; s.mreq = 0; s.st = X_LCK; s.mimo = 0; s.rel = 0;
    run_step("post_rst_lck", s);
    s.ticks = 1; s.st = X_RUN;
    run_step("post_rst_run", s);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cat_mode_sequencer.md
CAT_MODE_SEQUENCER -- requirements
Module: cat_mode_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: cycles io_areset is held high, and cycles waited after its release.
REQ-002 SHALL have parameter LOCK_COUNT, default 8: consecutive good strobe-pattern cycles required to declare lock.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 1024: maximum cycles spent in LOCK before failing.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: consecutive lock failures before halting in FAIL.
REQ-005 radio_clk  in  1  sole clock; all logic on rising edge.
REQ-006 radio_rst  in  1  synchronous, active-high reset.
REQ-007 mode_req  in  1  requested mode: 1=MIMO, 0=SISO; sampled when mode_req_stb=1.
REQ-008 mode_req_stb  in  1  single-cycle mode-change request.
REQ-009 rx_stb  in  1  RX sample strobe from the CMOS IO block.
REQ-010 mimo  out  1  mode driven to the CMOS IO block.
REQ-011 io_areset  out  1  reset driven to the CMOS IO block.
REQ-012 tx_enable  out  1  1 = TX samples pass; 0 = TX datapath forced to zero.
REQ-013 locked  out  1  high only in RUN.
REQ-014 busy  out  1  high in every state except RUN and FAIL.
REQ-015 lock_err  out  1  sticky; set on any lock failure; cleared on radio_rst or an accepted mode_req_stb.
REQ-016 relock_cnt  out  8  count of lock losses in RUN; saturates at 255; cleared only by radio_rst.

Function
REQ-017 States SHALL be: RESET, SETTLE, LOCK, RUN, QUIESCE, FAIL; encoding is free.
REQ-018 RESET: io_areset=1 and tx_enable=0 for exactly SETTLE_CYCLES cycles; mimo takes the pending mode on the first RESET cycle; then go to SETTLE.
REQ-019 SETTLE: io_areset=0 for SETTLE_CYCLES cycles; rx_stb ignored; then go to LOCK with match counter and timeout counter at 0.
REQ-020 LOCK good cycle: MIMO -> rx_stb differs from its value on the previous cycle; SISO -> rx_stb=1.
REQ-021 LOCK: good cycle increments the match counter; bad cycle clears it to 0; the timeout counter increments every cycle.
REQ-022 LOCK -> RUN on the cycle the match counter reaches LOCK_COUNT; the retry counter clears at the same time.
REQ-023 LOCK: timeout counter reaching LOCK_TIMEOUT before lock sets lock_err and increments the retry counter.
REQ-024 After a timeout, if retries < MAX_RETRIES, go to RESET; otherwise go to FAIL.
REQ-025 RUN: locked=1, tx_enable=1.
REQ-026 RUN loss of lock: two consecutive bad cycles -> relock_cnt+1 (saturating), go to QUIESCE; a single bad cycle is tolerated.
REQ-027 RUN: mode_req_stb with mode_req different from mimo -> capture as pending, go to QUIESCE.
REQ-028 RUN: mode_req_stb with mode_req equal to mimo SHALL be ignored.
REQ-029 QUIESCE: tx_enable=0, locked=0, io_areset=0 for exactly 4 cycles, then go to RESET.
REQ-030 FAIL: io_areset=0 and tx_enable=0; held until mode_req_stb (any value), which captures pending, clears lock_err and retries, and goes to QUIESCE.
REQ-031 mode_req_stb in RESET/SETTLE/LOCK/QUIESCE SHALL update pending only (latest wins); the sequence is not restarted.
REQ-032 A pending value differing from mimo at RUN entry SHALL cause immediate QUIESCE, without asserting locked.
REQ-033 tx_enable SHALL be registered and deassert on the same clock edge that leaves RUN.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 On radio_rst, SHALL enter RESET with SETTLE counter 0 and all other state, retry, match and timeout counters 0.
REQ-036 On radio_rst outputs SHALL be: mimo=0, pending=0, io_areset=1, tx_enable=0, locked=0, busy=1, lock_err=0, relock_cnt=0.
REQ-037 radio_rst mid-sequence SHALL abort the sequence and discard any pending request.

Verification
REQ-038 Reset, then rx_stb=1 constant -> io_areset high 16 cycles, low 16 cycles, locked=1 after 8 further cycles, mimo=0.
REQ-039 In RUN, pulse mode_req=1 with rx_stb toggling -> tx_enable=0 next edge, 4 QUIESCE cycles, mimo=1 on first RESET cycle, locked after 16+16+8 cycles.
REQ-040 MIMO mode, rx_stb stuck at 0 -> lock_err=1 after 1024 LOCK cycles; three retries, then FAIL with busy=0 and locked=0.
REQ-041 In RUN, one bad rx_stb cycle -> stays locked; two consecutive bad cycles -> relock_cnt=1, relock sequence runs.
REQ-042 mode_req_stb 1 then 0 during SETTLE (mimo=0) -> no restart; lock into RUN with mimo=0.
REQ-043 radio_rst asserted during LOCK -> next cycle io_areset=1, mimo=0, all counters 0.
